// File: rtl/sigmul_seq_ctrl_if.sv
// Handshake and data bundle for the sequential significand multiplier.
//   start  : multiply request (master -> slave)
//   x, y   : N-bit multiplicand / multiplier (master -> slave)
//   busy   : high while the multiplier is iterating (slave -> master)
//   done   : one-cycle completion pulse (slave -> master)
//   p      : 2N-bit registered product (slave -> master)
interface sigmul_seq_ctrl_if #(
  parameter int N = 11
);
  logic           start;
  logic [N-1:0]   x;
  logic [N-1:0]   y;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  modport master (output start, x, y, input busy, done, p);
  modport slave  (input start, x, y, output busy, done, p);
endinterface

// File: rtl/sigmul_seq_ctrl.sv
// Sequential shift-and-add significand multiplier (N x N -> 2N).
// One partial product is added per cycle through a single shared ripple
// adder. The accumulator is split into HI (upper N bits) and LO (lower N
// bits); LO starts as the multiplier and is shifted out as product bits
// are shifted in.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sigmul_seq_ctrl_if slave modport (start/x/y in, busy/done/p out)
// N must be at least 2.

module sigmul_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module sigmul_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for start; all registers hold
// RUN   | one add/shift iteration per cycle, N in total
// DONE  | product valid in p, done pulse, back to IDLE
module sigmul_seq_ctrl #(
  parameter int N = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  sigmul_seq_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]    state;
  logic [N-1:0]  mc;
  logic [N-1:0]  hi;
  logic [N-1:0]  lo;
  logic [CW-1:0] cnt;
  logic [2*N-1:0] p_q;

  logic [N-1:0]  addend;
  logic [N-1:0]  sum;
  logic [N:1]    carry;
  logic [N:0]    s;
  logic [N-1:0]  hi_nxt;
  logic [N-1:0]  lo_nxt;

  assign addend = lo[0] ? mc : '0;

  // Shared ripple adder: half adder in bit 0 (no carry in), full adders above.
  sigmul_ha u_ha0 (
    .a (hi[0]),
    .b (addend[0]),
    .s (sum[0]),
    .c (carry[1])
  );

  genvar gi;
  generate
    for (gi = 1; gi < N; gi++) begin : g_fa
      sigmul_fa u_fa (
        .a  (hi[gi]),
        .b  (addend[gi]),
        .ci (carry[gi]),
        .s  (sum[gi]),
        .co (carry[gi+1])
      );
    end
  endgenerate

  // Carry out is kept as the MSB so the product never overflows.
  assign s      = {carry[N], sum};
  assign hi_nxt = s[N:1];
  assign lo_nxt = {s[0], lo[N-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mc    <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      p_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mc    <= bus.x;
            lo    <= bus.y;
            hi    <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          hi <= hi_nxt;
          lo <= lo_nxt;
          if (cnt == LAST) begin
            // Final iteration: publish the post-update accumulator.
            // The counter parks at N-1 rather than wrapping.
            p_q   <= {hi_nxt, lo_nxt};
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.p    = p_q;

endmodule

// File: doc/sigmul_seq_ctrl.md
SIGMUL_SEQ_CTRL -- requirements
Module: sigmul_seq_ctrl

Interface
REQ-001 Parameter N, default 11: significand width in bits, hidden bit included.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  multiply request; accepted only in IDLE.
REQ-005 x  input  N  multiplicand; sampled on the accepting edge.
REQ-006 y  input  N  multiplier; sampled on the accepting edge.
REQ-007 busy  output  1  high while state is RUN.
REQ-008 done  output  1  high for exactly one cycle while state is DONE.
REQ-009 p  output  2N  registered product; holds its value until the next DONE.

Function
REQ-010 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-011 FSM SHALL encode its state in a 2-bit register.
REQ-012 IDLE with start=1 SHALL, on the edge:
  - load the multiplicand register MC with x;
  - load the low accumulator half LO with y;
  - clear the high accumulator half HI;
  - clear the iteration counter;
  - move to RUN.
REQ-013 IDLE with start=0 SHALL hold every register.
REQ-014 Each RUN edge SHALL compute S = HI + (LO[0] ? MC : 0) as an (N+1)-bit sum.
REQ-015 S SHALL come from a single N-bit ripple adder built from the team's half/full-adder bit cells, shared by all iterations.
REQ-016 Each RUN edge SHALL then update HI <= S[N:1] and LO <= {S[0], LO[N-1:1]}, and increment the counter.
REQ-017 The counter SHALL be ceil(log2(N)) bits wide and SHALL cover 0..N-1 with no wrap-around in RUN.
REQ-018 The RUN edge on which counter==N-1 SHALL load p <= {HI,LO} (post-update value) and move to DONE.
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-020 start SHALL be ignored in RUN and DONE.
REQ-021 x and y SHALL be ignored in every cycle except the accepting edge.
REQ-022 Latency: with start accepted at edge E0, done SHALL be high in the cycle following edge E_N (N+1 edges later, counting E0).
REQ-023 Back-to-back operation: the earliest next acceptance is the edge after DONE, so the minimum issue period is N+2 cycles.
REQ-024 The product SHALL be exact with no overflow, because an N x N product fits in 2N bits; the carry S[N] is always retained.
REQ-025 busy SHALL equal (state==RUN), and done SHALL equal (state==DONE), both decoded from registered state without glitches.
REQ-026 p SHALL not change except on the DONE-entry edge or on reset.

Reset
REQ-027 rst_n low SHALL immediately, without waiting for a clock edge, force:
  - state=IDLE, busy=0, done=0;
  - p=0, HI=0, LO=0, MC=0, counter=0.
REQ-028 Reset asserted in RUN or DONE SHALL abort the operation; no done pulse and no p update SHALL follow.
REQ-029 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-030 x=0x400, y=0x400 (1.0 x 1.0), one-cycle start -> busy high 11 cycles, then done pulse; p=0x100000.
REQ-031 x=0x600, y=0x600 (1.5 x 1.5) -> p=0x240000.
REQ-032 x=0x7FF, y=0x7FF (max) -> p=0x3FF001.
REQ-033 Accept x=0x7FF, y=0x7FF, then drive x=0, y=0, start=1 during RUN -> p=0x3FF001; exactly one done pulse.
REQ-034 Hold start=1 continuously with constant operands -> done pulses every 13 cycles; p is identical each time.
REQ-035 Reset pulsed at RUN iteration 5, then x=0x001, y=0x7FF -> no done pulse for the aborted operation; the next operation yields p=0x0007FF.
